// File: rtl/adder_tree_layer.sv
// ============================================================================
// adder_tree_layer : one pairwise-reduction layer of a binary adder tree
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_tree_layer #(
   parameter int INPUTS_AMOUNT  = 2,
   parameter int DATAW          = 5,
   parameter int SIGNED_OPS     = 1,
   parameter int REGISTER_OUT   = 0,
   localparam int OUTPUTS_AMOUNT = (INPUTS_AMOUNT + 1) / 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [DATAW-1:0] inputs  [INPUTS_AMOUNT],
   output logic [DATAW:0]   outputs [OUTPUTS_AMOUNT],
   output logic             out_valid
);

   logic [DATAW:0] w_ext [INPUTS_AMOUNT];
   logic [DATAW:0] w_sum [OUTPUTS_AMOUNT];

   if (INPUTS_AMOUNT < 1 || DATAW < 1) begin : g_bad_params
      $error("adder_tree_layer: INPUTS_AMOUNT and DATAW must both be >= 1");
   end

   for (genvar i = 0; i < INPUTS_AMOUNT; i++) begin : g_ext
      if (SIGNED_OPS != 0) begin : g_sext
         assign w_ext[i] = {inputs[i][DATAW-1], inputs[i]};
      end else begin : g_zext
         assign w_ext[i] = {1'b0, inputs[i]};
      end
   end

   // One extra bit of headroom makes every pair sum exact.
   for (genvar k = 0; k < OUTPUTS_AMOUNT; k++) begin : g_pair
      if (2 * k + 1 < INPUTS_AMOUNT) begin : g_add
         assign w_sum[k] = w_ext[2*k] + w_ext[2*k+1];
      end else begin : g_pass
         assign w_sum[k] = w_ext[2*k];
      end
   end

   if (REGISTER_OUT != 0) begin : g_reg
      logic [DATAW:0] r_out [OUTPUTS_AMOUNT];
      logic           r_valid;

      // Output data holds when in_valid is low; only the valid flag drops.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_out   <= '{default: '0};
            r_valid <= 1'b0;
         end else begin
            r_valid <= in_valid;
            if (in_valid) begin
               r_out <= w_sum;
            end
         end
      end

      assign outputs   = r_out;
      assign out_valid = r_valid;
   end else begin : g_comb
      logic w_unused;
      assign w_unused  = clk ^ rst;
      assign outputs   = w_sum;
      assign out_valid = in_valid;
   end

endmodule

`default_nettype wire

// File: tb/tb_adder_tree_layer.sv
// ============================================================================
// tb_adder_tree_layer : directed and model-based checks over several configs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_tree_layer;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Comb, N=4, DATAW=5, signed
   logic       c4_vld;
   logic [4:0] c4_in  [4];
   logic [5:0] c4_out [2];
   logic       c4_ov;
   adder_tree_layer #(.INPUTS_AMOUNT(4), .DATAW(5), .SIGNED_OPS(1), .REGISTER_OUT(0)) u_c4s (
      .clk(clk), .rst(rst), .in_valid(c4_vld), .inputs(c4_in), .outputs(c4_out), .out_valid(c4_ov));

   // Comb, N=2, DATAW=4, unsigned and signed on the same inputs
   logic       c2_vld;
   logic [3:0] c2_in   [2];
   logic [4:0] c2u_out [1];
   logic [4:0] c2s_out [1];
   logic       c2u_ov;
   logic       c2s_ov;
   adder_tree_layer #(.INPUTS_AMOUNT(2), .DATAW(4), .SIGNED_OPS(0), .REGISTER_OUT(0)) u_c2u (
      .clk(clk), .rst(rst), .in_valid(c2_vld), .inputs(c2_in), .outputs(c2u_out), .out_valid(c2u_ov));
   adder_tree_layer #(.INPUTS_AMOUNT(2), .DATAW(4), .SIGNED_OPS(1), .REGISTER_OUT(0)) u_c2s (
      .clk(clk), .rst(rst), .in_valid(c2_vld), .inputs(c2_in), .outputs(c2s_out), .out_valid(c2s_ov));

   // Comb, odd N=3, DATAW=4, signed; and N=1, DATAW=5
   logic       c3_vld;
   logic [3:0] c3_in  [3];
   logic [4:0] c3_out [2];
   logic       c3_ov;
   adder_tree_layer #(.INPUTS_AMOUNT(3), .DATAW(4), .SIGNED_OPS(1), .REGISTER_OUT(0)) u_c3s (
      .clk(clk), .rst(rst), .in_valid(c3_vld), .inputs(c3_in), .outputs(c3_out), .out_valid(c3_ov));
   logic [4:0] c1_in  [1];
   logic [5:0] c1_out [1];
   logic       c1_ov;
   adder_tree_layer #(.INPUTS_AMOUNT(1), .DATAW(5), .SIGNED_OPS(1), .REGISTER_OUT(0)) u_c1s (
      .clk(clk), .rst(rst), .in_valid(c3_vld), .inputs(c1_in), .outputs(c1_out), .out_valid(c1_ov));

   // Registered, N=2, DATAW=5, signed
   logic       r2_vld;
   logic [4:0] r2_in  [2];
   logic [5:0] r2_out [1];
   logic       r2_ov;
   adder_tree_layer #(.INPUTS_AMOUNT(2), .DATAW(5), .SIGNED_OPS(1), .REGISTER_OUT(1)) u_r2 (
      .clk(clk), .rst(rst), .in_valid(r2_vld), .inputs(r2_in), .outputs(r2_out), .out_valid(r2_ov));

   // Regression, N=8, DATAW=6, all four mode combinations on shared inputs
   logic       rg_vld;
   logic [5:0] rg_in   [8];
   logic [6:0] rcs_out [4];
   logic [6:0] rcu_out [4];
   logic [6:0] rrs_out [4];
   logic [6:0] rru_out [4];
   logic       rcs_ov, rcu_ov, rrs_ov, rru_ov;
   adder_tree_layer #(.INPUTS_AMOUNT(8), .DATAW(6), .SIGNED_OPS(1), .REGISTER_OUT(0)) u_rcs (
      .clk(clk), .rst(rst), .in_valid(rg_vld), .inputs(rg_in), .outputs(rcs_out), .out_valid(rcs_ov));
   adder_tree_layer #(.INPUTS_AMOUNT(8), .DATAW(6), .SIGNED_OPS(0), .REGISTER_OUT(0)) u_rcu (
      .clk(clk), .rst(rst), .in_valid(rg_vld), .inputs(rg_in), .outputs(rcu_out), .out_valid(rcu_ov));
   adder_tree_layer #(.INPUTS_AMOUNT(8), .DATAW(6), .SIGNED_OPS(1), .REGISTER_OUT(1)) u_rrs (
      .clk(clk), .rst(rst), .in_valid(rg_vld), .inputs(rg_in), .outputs(rrs_out), .out_valid(rrs_ov));
   adder_tree_layer #(.INPUTS_AMOUNT(8), .DATAW(6), .SIGNED_OPS(0), .REGISTER_OUT(1)) u_rru (
      .clk(clk), .rst(rst), .in_valid(rg_vld), .inputs(rg_in), .outputs(rru_out), .out_valid(rru_ov));

   function automatic logic [6:0] ext6(input logic [5:0] x, input bit sgn);
      return sgn ? {x[5], x} : {1'b0, x};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (r2_out[0] !== 6'd0 || r2_ov !== 1'b0) begin
         bad++;
         $display("FAIL reset_r2: out=%b valid=%b, want 000000 / 0", r2_out[0], r2_ov);
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rrs_out[k] !== 7'd0 || rru_out[k] !== 7'd0 || rrs_ov !== 1'b0 || rru_ov !== 1'b0) begin
            bad++;
            $display("FAIL reset_rg[%0d]: s=%b u=%b vs=%b vu=%b, want zeros", k, rrs_out[k], rru_out[k], rrs_ov, rru_ov);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_comb_signed();
      c4_vld = 1'b0;
      c4_in[0] = 5'd15; c4_in[1] = 5'd15; c4_in[2] = 5'b10000; c4_in[3] = 5'b10000;
      #1;
      total++;
      if (c4_out[0] !== 6'd30 || c4_out[1] !== 6'b100000 || c4_ov !== 1'b0) begin
         bad++;
         $display("FAIL comb_s4_a: out0=%b out1=%b ov=%b, want 011110 100000 0", c4_out[0], c4_out[1], c4_ov);
      end
      c4_vld = 1'b1;
      c4_in[0] = 5'b11011; c4_in[1] = 5'd3; c4_in[2] = 5'd0; c4_in[3] = 5'b11111;
      #1;
      total++;
      if (c4_out[0] !== 6'b111110 || c4_out[1] !== 6'b111111 || c4_ov !== 1'b1) begin
         bad++;
         $display("FAIL comb_s4_b: out0=%b out1=%b ov=%b, want 111110 111111 1", c4_out[0], c4_out[1], c4_ov);
      end
   endtask

   task automatic test_comb_unsigned();
      c2_vld = 1'b1;
      c2_in[0] = 4'b1111; c2_in[1] = 4'b1111;
      #1;
      total++;
      if (c2u_out[0] !== 5'b11110 || c2s_out[0] !== 5'b11110) begin
         bad++;
         $display("FAIL comb_2_ff: u=%b s=%b, want 11110 11110", c2u_out[0], c2s_out[0]);
      end
      c2_in[0] = 4'b1000; c2_in[1] = 4'b0001;
      #1;
      total++;
      if (c2u_out[0] !== 5'b01001 || c2s_out[0] !== 5'b11001) begin
         bad++;
         $display("FAIL comb_2_ext: u=%b s=%b, want 01001 11001", c2u_out[0], c2s_out[0]);
      end
   endtask

   task automatic test_odd();
      c3_vld = 1'b1;
      c3_in[0] = 4'd1; c3_in[1] = 4'd2; c3_in[2] = 4'b1000;
      c1_in[0] = 5'b10100;
      #1;
      total++;
      if (c3_out[0] !== 5'd3 || c3_out[1] !== 5'b11000) begin
         bad++;
         $display("FAIL odd_3: out0=%b out1=%b, want 00011 11000", c3_out[0], c3_out[1]);
      end
      total++;
      if (c1_out[0] !== 6'b110100 || c1_ov !== 1'b1) begin
         bad++;
         $display("FAIL single_1: out=%b ov=%b, want 110100 1", c1_out[0], c1_ov);
      end
   endtask

   task automatic test_registered();
      @(negedge clk);
      r2_vld = 1'b1; r2_in[0] = 5'd7; r2_in[1] = 5'b11101;
      @(posedge clk);
      #1;
      total++;
      if (r2_out[0] !== 6'd4 || r2_ov !== 1'b1) begin
         bad++;
         $display("FAIL reg_load: out=%b ov=%b, want 000100 1", r2_out[0], r2_ov);
      end
      @(negedge clk);
      r2_vld = 1'b0; r2_in[0] = 5'd1; r2_in[1] = 5'd1;
      @(posedge clk);
      #1;
      total++;
      if (r2_out[0] !== 6'd4 || r2_ov !== 1'b0) begin
         bad++;
         $display("FAIL reg_hold: out=%b ov=%b, want 000100 0", r2_out[0], r2_ov);
      end
   endtask

   task automatic test_reset_async();
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (r2_out[0] !== 6'd0 || r2_ov !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: out=%b ov=%b, want 000000 0", r2_out[0], r2_ov);
      end
      r2_vld = 1'b1; r2_in[0] = 5'd1; r2_in[1] = 5'd1;
      @(posedge clk);
      #1;
      total++;
      if (r2_out[0] !== 6'd0 || r2_ov !== 1'b0) begin
         bad++;
         $display("FAIL reset_held: out=%b ov=%b, want 000000 0", r2_out[0], r2_ov);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (r2_out[0] !== 6'd2 || r2_ov !== 1'b1) begin
         bad++;
         $display("FAIL reset_release: out=%b ov=%b, want 000010 1", r2_out[0], r2_ov);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] va [4];
      logic [4:0] vb [4];
      logic [5:0] ve [4];
      va[0] = 5'd3;     vb[0] = 5'd4;     ve[0] = 6'd7;
      va[1] = 5'b11111; vb[1] = 5'b11111; ve[1] = 6'b111110;
      va[2] = 5'd15;    vb[2] = 5'd15;    ve[2] = 6'd30;
      va[3] = 5'b10000; vb[3] = 5'b10000; ve[3] = 6'b100000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         r2_vld = 1'b1; r2_in[0] = va[i]; r2_in[1] = vb[i];
         @(posedge clk);
         #1;
         total++;
         if (r2_out[0] !== ve[i] || r2_ov !== 1'b1) begin
            bad++;
            $display("FAIL b2b[%0d]: out=%b ov=%b, want %b 1", i, r2_out[0], r2_ov, ve[i]);
         end
      end
      @(negedge clk);
      r2_vld = 1'b0;
   endtask

   task automatic test_regression();
      logic [6:0] cur_s [4];
      logic [6:0] cur_u [4];
      logic [6:0] exp_s [4];
      logic [6:0] exp_u [4];
      logic       exp_v;
      exp_s = '{default: '0};
      exp_u = '{default: '0};
      exp_v = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         rg_vld = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 8; i++) rg_in[i] = 6'($urandom);
         for (int k = 0; k < 4; k++) begin
            cur_s[k] = ext6(rg_in[2*k], 1'b1) + ext6(rg_in[2*k+1], 1'b1);
            cur_u[k] = ext6(rg_in[2*k], 1'b0) + ext6(rg_in[2*k+1], 1'b0);
         end
         #1;
         for (int k = 0; k < 4; k++) begin
            total++;
            if (rcs_out[k] !== cur_s[k] || rcu_out[k] !== cur_u[k] || rcs_ov !== rg_vld || rcu_ov !== rg_vld) begin
               bad++;
               $display("FAIL rg_comb[%0d] vec %0d: s=%b u=%b, want s=%b u=%b", k, n, rcs_out[k], rcu_out[k], cur_s[k], cur_u[k]);
            end
         end
         if (rg_vld) begin
            exp_s = cur_s;
            exp_u = cur_u;
         end
         exp_v = rg_vld;
         @(posedge clk);
         #1;
         for (int k = 0; k < 4; k++) begin
            total++;
            if (rrs_out[k] !== exp_s[k] || rru_out[k] !== exp_u[k] || rrs_ov !== exp_v || rru_ov !== exp_v) begin
               bad++;
               $display("FAIL rg_reg[%0d] vec %0d: s=%b u=%b v=%b, want s=%b u=%b v=%b", k, n, rrs_out[k], rru_out[k], rrs_ov, exp_s[k], exp_u[k], exp_v);
            end
         end
      end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst    = 1'b0;
      c4_vld = 1'b0;
      c2_vld = 1'b0;
      c3_vld = 1'b0;
      r2_vld = 1'b0;
      rg_vld = 1'b0;
      c4_in  = '{default: '0};
      c2_in  = '{default: '0};
      c3_in  = '{default: '0};
      c1_in  = '{default: '0};
      r2_in  = '{default: '0};
      rg_in  = '{default: '0};
      test_reset();
      test_comb_signed();
      test_comb_unsigned();
      test_odd();
      test_registered();
      test_reset_async();
      test_back_to_back();
      test_regression();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
